// File: rtl/rtc_pkg.sv
// Shared RTC definitions: per-field bounds, the two-digit BCD field type,
// and a constant-friendly binary-to-BCD helper.
package rtc_pkg;

    localparam int unsigned SEC_MIN  = 0;
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MIN  = 0;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MIN = 0;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned DAY_MIN  = 1;
    localparam int unsigned DAY_MAX  = 31;
    localparam int unsigned MON_MIN  = 1;
    localparam int unsigned MON_MAX  = 12;
    localparam int unsigned YEAR_MIN = 0;
    localparam int unsigned YEAR_MAX = 99;

    localparam int unsigned BCD_W = 8;

    // Two-digit BCD value; tens in the upper nibble.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_field_t;

    // Binary (0-99) to BCD; used for elaboration-time constants such as reset values.
    function automatic bcd_field_t to_bcd(input int unsigned v);
        bcd_field_t r;
        r.tens  = 4'(v / 32'd10);
        r.units = 4'(v % 32'd10);
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_2dig.sv
// Combinational binary (0-99) to two-digit BCD converter.
// Ports:
//   bin_i  binary input, 0..99
//   bcd_o  BCD output, tens/units nibbles
module bin2bcd_2dig
    import rtc_pkg::*;
#(
    parameter int unsigned BIN_W = 7
) (
    input  logic [BIN_W-1:0] bin_i,
    output bcd_field_t       bcd_o
);

    localparam logic [BIN_W-1:0] TEN = BIN_W'(10);

    // Constant divisor, so this reduces to a small fixed-function network.
    always_comb begin
        bcd_o       = '0;
        bcd_o.tens  = 4'(bin_i / TEN);
        bcd_o.units = 4'(bin_i % TEN);
    end

endmodule

// File: rtl/bcd_field_counter.sv
// Two-digit BCD calendar/time field register with load, inc/dec and
// carry chaining. Wraps between MIN_VAL and MAX_VAL and pulses carry/borrow.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   en           field enable; low holds all state and zeroes pulses
//   load/load_val binary load, rejected (load_err) when out of range
//   inc/dec      user step requests; carry_in from the lower field
//   value_bin    current value, binary
//   value_bcd    current value, BCD
//   carry_out    one-cycle pulse on MAX_VAL->MIN_VAL wrap
//   borrow_out   one-cycle pulse on MIN_VAL->MAX_VAL wrap
//   load_err     one-cycle pulse on rejected load
module bcd_field_counter
    import rtc_pkg::*;
#(
    parameter int unsigned MIN_VAL = 1,
    parameter int unsigned MAX_VAL = 12,
    parameter int unsigned BIN_W   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [BIN_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic             carry_in,
    output logic [BIN_W-1:0] value_bin,
    output logic [7:0]       value_bcd,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             load_err
);

    localparam logic [BIN_W-1:0] MIN_B   = BIN_W'(MIN_VAL);
    localparam logic [BIN_W-1:0] MAX_B   = BIN_W'(MAX_VAL);
    localparam bcd_field_t       MIN_BCD = to_bcd(MIN_VAL);

    logic [BIN_W-1:0] value_q, value_d;
    bcd_field_t       bcd_q, bcd_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             err_q, err_d;

    logic step_up;
    logic step_dn;
    logic load_ok;
    int   load_int;

    assign step_up  = inc | carry_in;
    assign step_dn  = dec;
    // Signed compare keeps a MIN_VAL of 0 from becoming a trivially true test.
    assign load_int = int'(load_val);
    assign load_ok  = (load_int >= int'(MIN_VAL)) && (load_int <= int'(MAX_VAL));

    // Next value and pulses: load beats stepping; opposing steps cancel.
    always_comb begin
        value_d  = value_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        err_d    = 1'b0;
        if (en) begin
            if (load) begin
                if (load_ok) begin
                    value_d = load_val;
                end else begin
                    err_d = 1'b1;
                end
            end else if (step_up && !step_dn) begin
                if (value_q == MAX_B) begin
                    value_d = MIN_B;
                    carry_d = 1'b1;
                end else begin
                    value_d = value_q + BIN_W'(1);
                end
            end else if (step_dn && !step_up) begin
                if (value_q == MIN_B) begin
                    value_d  = MAX_B;
                    borrow_d = 1'b1;
                end else begin
                    value_d = value_q - BIN_W'(1);
                end
            end
        end
    end

    // BCD is derived from the next value so both outputs change on the same edge.
    bin2bcd_2dig #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .bin_i (value_d),
        .bcd_o (bcd_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q  <= MIN_B;
            bcd_q    <= MIN_BCD;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            value_q  <= value_d;
            bcd_q    <= bcd_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
        end
    end

    assign value_bin  = value_q;
    assign value_bcd  = bcd_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_bcd_field_counter.sv
// Directed bench for bcd_field_counter: default month field plus a 0..59 field.
module tb_bcd_field_counter;

    logic clk = 1'b0;
    logic reset;

    // Default (month) instance
    logic       en, load, inc, dec, carry_in;
    logic [6:0] load_val;
    logic [6:0] value_bin;
    logic [7:0] value_bcd;
    logic       carry_out, borrow_out, load_err;

    // 0..59 instance
    logic       s_en, s_load, s_inc, s_dec, s_cin;
    logic [6:0] s_load_val;
    logic [6:0] s_value_bin;
    logic [7:0] s_value_bcd;
    logic       s_carry_out, s_borrow_out, s_load_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_field_counter u_mon (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .load_val   (load_val),
        .inc        (inc),
        .dec        (dec),
        .carry_in   (carry_in),
        .value_bin  (value_bin),
        .value_bcd  (value_bcd),
        .carry_out  (carry_out),
        .borrow_out (borrow_out),
        .load_err   (load_err)
    );

    bcd_field_counter #(
        .MIN_VAL (0),
        .MAX_VAL (59),
        .BIN_W   (7)
    ) u_sec (
        .clk        (clk),
        .reset      (reset),
        .en         (s_en),
        .load       (s_load),
        .load_val   (s_load_val),
        .inc        (s_inc),
        .dec        (s_dec),
        .carry_in   (s_cin),
        .value_bin  (s_value_bin),
        .value_bcd  (s_value_bcd),
        .carry_out  (s_carry_out),
        .borrow_out (s_borrow_out),
        .load_err   (s_load_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mon(input string tag, input int v, input logic [7:0] b,
                           input logic c, input logic bo, input logic e);
        check_eq({tag, ".bin"},    32'(value_bin),  32'(v));
        check_eq({tag, ".bcd"},    32'(value_bcd),  32'(b));
        check_eq({tag, ".carry"},  32'(carry_out),  32'(c));
        check_eq({tag, ".borrow"}, 32'(borrow_out), 32'(bo));
        check_eq({tag, ".err"},    32'(load_err),   32'(e));
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load = 1'b0; inc = 1'b0; dec = 1'b0; carry_in = 1'b0; en = 1'b1;
    endtask

    task automatic do_load(input int v);
        idle();
        load = 1'b1;
        load_val = 7'(v);
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        load_val = '0;
        s_en = 1'b1; s_load = 1'b0; s_inc = 1'b0; s_dec = 1'b0; s_cin = 1'b0;
        s_load_val = '0;
        #1;
        tick();
        tick();
        chk_mon("reset", 1, 8'h01, 1'b0, 1'b0, 1'b0);
        check_eq("sec_reset.bcd", 32'(s_value_bcd), 32'h00);
        reset = 1'b0;

        // Wrap up and back down
        do_load(12);
        chk_mon("load12", 12, 8'h12, 1'b0, 1'b0, 1'b0);
        inc = 1'b1; tick(); idle();
        chk_mon("wrap_up", 1, 8'h01, 1'b1, 1'b0, 1'b0);
        tick();
        chk_mon("wrap_up_after", 1, 8'h01, 1'b0, 1'b0, 1'b0);
        dec = 1'b1; tick(); idle();
        chk_mon("wrap_dn", 12, 8'h12, 1'b0, 1'b1, 1'b0);
        tick();
        chk_mon("wrap_dn_after", 12, 8'h12, 1'b0, 1'b0, 1'b0);

        // Out-of-range loads
        do_load(13);
        chk_mon("load13", 12, 8'h12, 1'b0, 1'b0, 1'b1);
        tick();
        chk_mon("load13_after", 12, 8'h12, 1'b0, 1'b0, 1'b0);
        do_load(0);
        chk_mon("load0", 12, 8'h12, 1'b0, 1'b0, 1'b1);
        do_load(9);
        chk_mon("load9", 9, 8'h09, 1'b0, 1'b0, 1'b0);
        do_load(10);
        chk_mon("load10", 10, 8'h10, 1'b0, 1'b0, 1'b0);

        // Simultaneous requests
        do_load(5);
        inc = 1'b1; dec = 1'b1; tick(); idle();
        chk_mon("inc_dec", 5, 8'h05, 1'b0, 1'b0, 1'b0);
        inc = 1'b1; carry_in = 1'b1; tick(); idle();
        chk_mon("inc_cin", 6, 8'h06, 1'b0, 1'b0, 1'b0);
        load = 1'b1; load_val = 7'd3; inc = 1'b1; tick(); idle();
        chk_mon("load_inc", 3, 8'h03, 1'b0, 1'b0, 1'b0);

        // Disabled field ignores a held inc
        en = 1'b0; inc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_mon("en_low", 3, 8'h03, 1'b0, 1'b0, 1'b0);
        end
        idle();

        // Held inc counts every cycle through the wrap
        do_load(10);
        inc = 1'b1;
        tick(); chk_mon("held1", 11, 8'h11, 1'b0, 1'b0, 1'b0);
        tick(); chk_mon("held2", 12, 8'h12, 1'b0, 1'b0, 1'b0);
        tick(); chk_mon("held3", 1,  8'h01, 1'b1, 1'b0, 1'b0);
        tick(); chk_mon("held4", 2,  8'h02, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an inc burst
        tick(); chk_mon("burst", 3, 8'h03, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(); chk_mon("burst_reset", 1, 8'h01, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); chk_mon("burst_resume", 2, 8'h02, 1'b0, 1'b0, 1'b0);
        idle();

        // Full 0..59 sweep driven by carry_in
        check_eq("sweep_start", 32'(s_value_bcd), 32'h00);
        s_cin = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            int v;
            logic [7:0] b;
            tick();
            v = i % 60;
            b = 8'(((v / 10) << 4) | (v % 10));
            check_eq("sweep.bin",   32'(s_value_bin), 32'(v));
            check_eq("sweep.bcd",   32'(s_value_bcd), 32'(b));
            check_eq("sweep.carry", 32'(s_carry_out), (i == 60) ? 32'd1 : 32'd0);
        end
        s_cin = 1'b0;
        tick();
        check_eq("sweep_carry_clear", 32'(s_carry_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_field_counter.md
# bcd_field_counter

- Parametrised two-digit BCD calendar/time field register: month (1–12) by default, retargetable to seconds, minutes, hours, day or year by parameter.
- Holds the field value, which can be loaded from a binary value, incremented, decremented, or advanced by a carry from the next-lower field.
- Wraps at the configured bounds and emits a one-cycle carry/borrow pulse, so fields chain into a full clock/calendar.
- Sits between the RTC user-edit logic and the display/RTC-write path.

## Interface
Parameters:
- MIN_VAL, 1, lowest legal field value (0 for sec/min/hour, 1 for day/month)
- MAX_VAL, 12, highest legal field value; MIN_VAL < MAX_VAL ≤ 99
- BIN_W, 7, width of binary load and binary value ports; must hold MAX_VAL

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- en  in  1  field enable; when low, inc/dec/carry_in/load are ignored and outputs hold
- load  in  1  load load_val this cycle
- load_val  in  BIN_W  binary value to load
- inc  in  1  user increment request (one step per asserted cycle)
- dec  in  1  user decrement request
- carry_in  in  1  increment from the lower field's carry_out
- value_bin  out  BIN_W  current value, binary
- value_bcd  out  8  current value, BCD; [7:4] tens, [3:0] units
- carry_out  out  1  one-cycle pulse on MAX_VAL→MIN_VAL wrap
- borrow_out  out  1  one-cycle pulse on MIN_VAL→MAX_VAL wrap
- load_err  out  1  one-cycle pulse when a load is rejected as out of range

## Operation
- Step is up = inc | carry_in; down = dec.
- Priority, highest first: reset, then en low (hold), then load, then step.
- Load:
  - MIN_VAL ≤ load_val ≤ MAX_VAL: value ← load_val.
  - Otherwise: value unchanged and load_err = 1.
  - No carry or borrow is generated by a load.
  - inc, dec and carry_in are ignored in the load cycle.
- Stepping:
  - up only: value ← value+1, or MIN_VAL with carry_out=1 if value==MAX_VAL.
  - down only: value ← value−1, or MAX_VAL with borrow_out=1 if value==MIN_VAL.
  - up and down together: no change, no pulse.
  - inc and carry_in together count as one step, not two.
- value_bcd is always the exact BCD encoding of value_bin.
  - Never an illegal digit (>9).
  - Both outputs update on the same edge.
- The value is never outside [MIN_VAL, MAX_VAL] in any cycle.
- carry_out, borrow_out and load_err are 0 in every cycle without the triggering event.

## Timing
- Reset values: value_bin = MIN_VAL; value_bcd = BCD(MIN_VAL) (8'h01 by default); carry_out = 0; borrow_out = 0; load_err = 0.
- Reset asserted mid-sequence overrides load, step and en on that edge; pulses clear on that edge.
- Latency:
  - One clock from a sampled load/inc/dec/carry_in to the new value_bin/value_bcd.
  - carry_out, borrow_out and load_err are registered and assert in the same cycle as the new value; each is high for exactly one cycle.
- Chaining: a lower field's carry_out drives the upper field's carry_in, so the upper field updates one cycle after the lower field wraps. This one-cycle ripple per field is accepted.
- Held inc for N cycles gives N steps; there is no edge detection inside the block. Debounce/one-shot is upstream.
- en low: all outputs hold, and pulses are 0.

## Structure
- Shared package (rtc_pkg):
  - field bound constants: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, DAY_MIN=1, DAY_MAX=31, MON_MIN=1, MON_MAX=12, YEAR_MAX=99
  - BCD field type (8 bit, two nibbles)
- One sub-module, bin2bcd_2dig: combinational binary (0–99) to two-digit BCD.
  - Applied to the next-value before the register, so value_bcd is registered.
- Counter, range check and priority logic stay in bcd_field_counter.

## Test plan
- Reset with defaults → value_bin=1, value_bcd=8'h01, all pulses 0; assert reset during an inc burst → value returns to 1 on that edge.
- Load 12, then inc one cycle → value 1 / 8'h01 with carry_out=1 for exactly one cycle; then dec one cycle → value 12 / 8'h12 with borrow_out=1.
- Load 13 and load 0 (defaults) → value unchanged, load_err=1 for one cycle each; load 9 → value_bcd=8'h09; load 10 → 8'h10.
- inc=1 with dec=1 at value 5 → stays 5, no pulses; inc=1 with carry_in=1 at value 5 → 6 (single step); load=1 with inc=1, load_val=3 → 3.
- en=0 with inc held for 4 cycles → value and outputs unchanged; en=1 with inc held for 4 cycles from 10 → 11, 12, 1 (carry), 2.
- MIN_VAL=0, MAX_VAL=59: 60 carry_in pulses from 0 → values sweep 8'h00..8'h59, every digit ≤9, then one carry_out on the 59→0 wrap.
